// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer, and a saturating downstream-stall counter.
module pipe_stage_reg #(
  parameter int unsigned WIDTH       = 32,
  parameter bit          SKID        = 1'b1,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_q, s_q;
  logic             acc, fire;
  logic             load_in, load_skid, shift;

  assign acc       = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = (ZERO_BUBBLE && state == EMPTY) ? '0 : m_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Flush overrides everything: handshakes still complete, but nothing is loaded.
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          load_in   = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (acc && fire) begin
            load_in = 1'b1;
          end else if (acc && SKID) begin
            load_skid = 1'b1;
            state_nxt = TWO;
          end else if (fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (fire) begin
          shift     = 1'b1;
          state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_in)    m_q <= in_data;
      else if (shift) m_q <= s_q;
      if (load_skid)  s_q <= in_data;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready: breaks the out_ready -> in_ready path upstream.
      logic rdy_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= (state_nxt != TWO);
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      logic en_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= 1'b1;
      end
      assign in_ready = en_q && (!out_valid || out_ready);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=0 and a SKID=1 instance share stimulus; each
// is tracked by a FIFO-level reference model acting as the scoreboard.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  oc0, oc1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int passed = 0;
  int total  = 0;

  // Reference model state, index 0 = u0 (SKID=0, ZB=0), 1 = u1 (SKID=1, ZB=1, CNT_W=4)
  logic [31:0] fifo [2][2];
  int          n       [2];
  logic [31:0] mlast   [2];
  int          cnt     [2];
  bit          started [2];
  int          cmax    [2] = '{65535, 15};
  bit          skid_p  [2] = '{1'b0, 1'b1};
  bit          zb_p    [2] = '{1'b0, 1'b1};

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .ZERO_BUBBLE(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0), .stall_cnt(sc0));

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .ZERO_BUBBLE(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1), .stall_cnt(sc1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle of the model, evaluated mid-cycle with inputs stable.
  task automatic step(input int k, input logic ir, input logic ov, input logic [31:0] od,
                      input logic [1:0] oc, input logic [31:0] sc);
    logic        er, ev;
    logic [31:0] ed;
    bit          acc, fire;
    string       p;
    p = $sformatf("u%0d ", k);
    if (rst) begin
      n[k] = 0; mlast[k] = 0; cnt[k] = 0; started[k] = 1'b0;
      chk({p, "rst in_ready"},  32'(ir), 32'd0);
      chk({p, "rst out_valid"}, 32'(ov), 32'd0);
      chk({p, "rst out_data"},  od,      32'd0);
      chk({p, "rst occupancy"}, 32'(oc), 32'd0);
      chk({p, "rst stall_cnt"}, sc,      32'd0);
    end else begin
      ev = (n[k] > 0);
      er = started[k] && (skid_p[k] ? (n[k] < 2) : (n[k] == 0 || out_ready));
      ed = ev ? fifo[k][0] : (zb_p[k] ? 32'd0 : mlast[k]);
      chk({p, "in_ready"},  32'(ir), 32'(er));
      chk({p, "out_valid"}, 32'(ov), 32'(ev));
      chk({p, "out_data"},  od,      ed);
      chk({p, "occupancy"}, 32'(oc), n[k]);
      chk({p, "stall_cnt"}, sc,      cnt[k]);
      acc  = in_valid && er;
      fire = ev && out_ready;
      if (ev && !out_ready && cnt[k] < cmax[k]) cnt[k]++;
      if (flush) begin
        n[k] = 0;
      end else begin
        if (fire) begin
          chk({p, "xfer data"}, od, fifo[k][0]);
          fifo[k][0] = fifo[k][1];
          n[k]--;
        end
        if (acc) begin
          fifo[k][n[k]] = in_data;
          n[k]++;
        end
      end
      if (n[k] > 0) mlast[k] = fifo[k][0];
      started[k] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    step(0, ir0, ov0, od0, oc0, 32'(sc0));
    step(1, ir1, ov1, od1, oc1, 32'(sc1));
  end

  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clk); #1;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Stream with downstream always ready
    cyc(1, 32'h11, 1, 0); cyc(1, 32'h22, 1, 0); cyc(1, 32'h33, 1, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);

    // Skid fill then drain
    cyc(1, 32'hA, 1, 0); cyc(1, 32'hB, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);

    // Flush while full and stalled
    cyc(1, 32'hA, 0, 0); cyc(1, 32'hB, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Combinational backpressure on the single-entry stage, then replacement
    cyc(1, 32'h5, 1, 0); cyc(1, 32'h99, 0, 0); cyc(1, 32'h6, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);

    // Counter saturation, held across a flush
    repeat (20) cyc(1, $urandom, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    #3 chk("u1 stall_cnt saturated", 32'(sc1), 32'd15);

    // Asynchronous reset between edges while the skid stage is full
    cyc(1, 32'h1, 0, 0); cyc(1, 32'h2, 0, 0); cyc(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("u1 full before rst", 32'(oc1), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("u1 async out_valid", 32'(ov1), 32'd0);
    chk("u1 async out_data",  od1,      32'd0);
    chk("u1 async occupancy", 32'(oc1), 32'd0);
    chk("u1 async stall_cnt", 32'(sc1), 32'd0);
    chk("u1 async in_ready",  32'(ir1), 32'd0);
    chk("u0 async out_data",  od0,      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(0, 0, 1, 0);

    // Randomised traffic
    repeat (400)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0);
    repeat (4) cyc(0, 0, 1, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
